ask_tx_sched: RTL and testbench



---
 rtl/ask_tx_sched.sv | 152 +++++++++++++++
 tb/tb_ask_tx_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ask_tx_sched.sv
// Two-requester frame scheduler driving the 2ASK modulator word bus.
// Define ASK_SCHED_FIXED_PRIO_EN for fixed channel-0 priority (default: round-robin).
module ask_tx_sched #(
  parameter int unsigned B_FREQ     = 49,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned GAP_BITS   = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data0,
  input  logic [15:0] req_data1,
  output logic [1:0]  req_ready,
  output logic [15:0] tx_data,
  output logic        tx_busy,
  output logic        tx_grant,
  output logic        frame_done
);

  localparam int unsigned CycW   = (B_FREQ > 0) ? $clog2(B_FREQ + 1) : 1;
  localparam int unsigned BitMax = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int unsigned BitW   = (BitMax > 0) ? $clog2(BitMax + 1) : 1;
  localparam bit          HasGap = (GAP_BITS != 0);

  localparam logic [CycW-1:0] CycLast   = CycW'(B_FREQ);
  localparam logic [CycW-1:0] CycOne    = CycW'(1);
  localparam logic [BitW-1:0] BitOne    = BitW'(1);
  localparam logic [BitW-1:0] FrameLast = BitW'(FRAME_BITS - 1);
  localparam logic [BitW-1:0] GapLast   = BitW'(HasGap ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {StIdle, StKick, StSend, StGap} state_e;

  state_e          state_q, state_d;
  logic [15:0]     tx_data_q, tx_data_d;
  logic [15:0]     word_q, word_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [BitW-1:0] bit_q, bit_d;

  logic [1:0]  cand;
  logic        sel;
  logic        go;
  logic [15:0] xfer_word;
  logic        cyc_end;

  // Arbitration: sel names the winning channel; only meaningful when cand != 0.
  always_comb begin
    cand = req_valid & {2{tx_en}};
`ifdef ASK_SCHED_FIXED_PRIO_EN
    sel = ~cand[0];
`else
    if (cand == 2'b11) begin
      sel = ~last_grant_q;
    end else begin
      sel = ~cand[0];
    end
`endif
    go        = (state_q == StIdle) && (cand != 2'b00);
    req_ready = go ? (sel ? 2'b10 : 2'b01) : 2'b00;
    xfer_word = sel ? req_data1 : req_data0;
  end

  assign cyc_end = (cyc_q == CycLast);

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    word_d       = word_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    frame_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          grant_d      = sel;
          last_grant_d = sel;
          word_d       = xfer_word;
          // An unchanged word would not restart the modulator, so flip it for one cycle.
          if (xfer_word != tx_data_q) begin
            tx_data_d = xfer_word;
            state_d   = StSend;
          end else begin
            tx_data_d = ~xfer_word;
            state_d   = StKick;
          end
        end
      end
      StKick: begin
        tx_data_d = word_q;
        state_d   = StSend;
      end
      StSend: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (bit_q == FrameLast) begin
            frame_done = 1'b1;
            bit_d      = '0;
            state_d    = HasGap ? StGap : StIdle;
          end else begin
            bit_d = bit_q + BitOne;
          end
        end else begin
          cyc_d = cyc_q + CycOne;
        end
      end
      StGap: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (bit_q == GapLast) begin
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + BitOne;
          end
        end else begin
          cyc_d = cyc_q + CycOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      tx_data_q    <= 16'h0000;
      word_q       <= 16'h0000;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cyc_q        <= '0;
      bit_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      word_q       <= word_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_grant = grant_q;

endmodule

// File: tb/tb_ask_tx_sched.sv
// Directed self-checking bench for ask_tx_sched (B_FREQ=3; one instance with GAP_BITS=2,
// one with GAP_BITS=0).
module tb_ask_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  valid;
  logic [15:0] d0, d1;
  logic [1:0]  ready;
  logic [15:0] txd;
  logic        busy, grant, fd;

  logic        g_en;
  logic [1:0]  g_valid;
  logic [15:0] g_d0, g_d1;
  logic [1:0]  g_ready;
  logic [15:0] g_txd;
  logic        g_busy, g_grant, g_fd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ask_tx_sched #(.B_FREQ(3), .FRAME_BITS(16), .GAP_BITS(2)) dut (
    .sys_clk(clk), .sys_rst(rst), .tx_en(en), .req_valid(valid),
    .req_data0(d0), .req_data1(d1), .req_ready(ready), .tx_data(txd),
    .tx_busy(busy), .tx_grant(grant), .frame_done(fd)
  );

  ask_tx_sched #(.B_FREQ(3), .FRAME_BITS(16), .GAP_BITS(0)) dut_g0 (
    .sys_clk(clk), .sys_rst(rst), .tx_en(g_en), .req_valid(g_valid),
    .req_data0(g_d0), .req_data1(g_d1), .req_ready(g_ready), .tx_data(g_txd),
    .tx_busy(g_busy), .tx_grant(g_grant), .frame_done(g_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic exp_g;
    rst = 1'b1; en = 1'b0; valid = 2'b00; d0 = '0; d1 = '0;
    g_en = 1'b0; g_valid = 2'b00; g_d0 = '0; g_d1 = '0;

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_txd", txd, 32'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_fd", fd, 0);
    chk("rst_ready", ready, 0);
    tick(); rst = 1'b0;
    tick();

    // Single word from ch0, transfer at T
    en = 1'b1; valid = 2'b01; d0 = 16'hA5C3;
    #1 chk("t1_ready", ready, 2'b01);
    tick(); valid = 2'b00;
    #1;
    chk("t1_ready_drop", ready, 2'b00);
    chk("t1_txd", txd, 16'hA5C3);
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant, 0);
    repeat (62) tick();
    #1 chk("t1_fd_early", fd, 0);
    tick(); #1 chk("t1_fd", fd, 1);
    tick(); #1;
    chk("t1_fd_pulse", fd, 0);
    chk("t1_gap_busy", busy, 1);
    chk("t1_gap_txd", txd, 16'hA5C3);
    repeat (7) tick();
    #1 chk("t1_gap_end_busy", busy, 1);
    tick(); #1 chk("t1_idle", busy, 0);

    // Identical repeat from ch1
    valid = 2'b10; d1 = 16'h00FF;
    #1 chk("t2_ready", ready, 2'b10);
    tick(); #1;
    chk("t2_txd", txd, 16'h00FF);
    chk("t2_grant", grant, 1);
    repeat (72) tick();
    #1 chk("t2_ready2", ready, 2'b10);
    tick(); valid = 2'b00;
    #1;
    chk("t2_kick_txd", txd, 16'hFF00);
    chk("t2_kick_busy", busy, 1);
    tick(); #1 chk("t2_send_txd", txd, 16'h00FF);
    repeat (62) tick();
    #1 chk("t2_fd_early", fd, 0);
    tick(); #1;
    chk("t2_fd", fd, 1);
    chk("t2_fd_txd", txd, 16'h00FF);
    wait_idle();

    // Contention
    valid = 2'b11; d0 = 16'h1111; d1 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      wait_idle();
`ifdef ASK_SCHED_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = k[0];
`endif
      #1 chk("t3_ready", ready, exp_g ? 2'b10 : 2'b01);
      tick(); #1 chk("t3_grant", grant, exp_g);
      tick(); #1 chk("t3_txd", txd, exp_g ? 16'h2222 : 16'h1111);
    end
    valid = 2'b00;
    wait_idle();

    // tx_en gating
    en = 1'b0; valid = 2'b01; d0 = 16'hBEEF;
    #1 chk("t4_ready_off", ready, 2'b00);
    repeat (3) tick();
    #1;
    chk("t4_ready_off2", ready, 2'b00);
    chk("t4_busy_off", busy, 0);
    en = 1'b1;
    #1 chk("t4_ready_on", ready, 2'b01);
    tick(); valid = 2'b00;
    #1;
    chk("t4_txd", txd, 16'hBEEF);
    chk("t4_busy", busy, 1);

    // Reset mid-SEND at bit 7
    repeat (28) tick();
    #1;
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_fd", fd, 0);
    rst = 1'b1;
    #1;
    chk("t5_txd", txd, 16'h0000);
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant, 0);
    chk("t5_fd", fd, 0);
    chk("t5_ready", ready, 2'b00);
    tick(); rst = 1'b0;
    tick();
    valid = 2'b11; d0 = 16'h1234; d1 = 16'h5678;
    #1 chk("t5_tie_ready", ready, 2'b01);
    tick(); valid = 2'b00;
    #1;
    chk("t5_txd2", txd, 16'h1234);
    chk("t5_grant2", grant, 0);
    chk("t5_busy2", busy, 1);
    wait_idle();

    // GAP_BITS=0 instance
    g_en = 1'b1; g_valid = 2'b01; g_d0 = 16'hC001;
    #1 chk("t6_ready", g_ready, 2'b01);
    tick(); g_d0 = 16'hC002;
    #1;
    chk("t6_txd", g_txd, 16'hC001);
    chk("t6_ready_busy", g_ready, 2'b00);
    repeat (63) tick();
    #1;
    chk("t6_fd", g_fd, 1);
    chk("t6_fd_busy", g_busy, 1);
    tick(); #1;
    chk("t6_idle", g_busy, 0);
    chk("t6_ready2", g_ready, 2'b01);
    tick(); g_valid = 2'b00;
    #1 chk("t6_txd2", g_txd, 16'hC002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
